// File: rtl/mux_seq_alu_pkg.sv
// mux_seq_alu_pkg: opcode/state types and phase-count helper for the bit-serial mux ALU
package mux_seq_alu_pkg;
  typedef enum logic [1:0] {OP_AND = 2'b00, OP_OR = 2'b01, OP_XOR = 2'b10, OP_NAND = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  function automatic logic two_phase(op_e op);
    return op == OP_XOR || op == OP_NAND;
  endfunction
endpackage

// File: rtl/mux_seq_alu_if.sv
// mux_seq_alu_if: request/response valid-ready bus of the bit-serial mux ALU
interface mux_seq_alu_if #(parameter int W = 8);
  import mux_seq_alu_pkg::*;
  logic in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] in_a, in_b, out_res;
  op_e in_op;
  modport master (output in_valid, in_a, in_b, in_op, out_ready, input in_ready, out_valid, out_res);
  modport slave (input in_valid, in_a, in_b, in_op, out_ready, output in_ready, out_valid, out_res);
endinterface

// File: rtl/mux_seq_alu_mux.sv
// mux: single-bit 2:1 multiplexer, y = sel ? d1 : d0
module mux (
  input  logic d0,
  input  logic d1,
  input  logic sel,
  output logic y
);
  assign y = sel ? d1 : d0;
endmodule

// File: rtl/mux_seq_alu.sv
// mux_seq_alu: bit-serial AND/OR/XOR/NAND sequenced through one shared 1-bit mux
module mux_seq_alu import mux_seq_alu_pkg::*; #(parameter int W = 8) (
  input logic clk,
  input logic rst_n,
  mux_seq_alu_if.slave bus
);
  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] LAST = IW'(W - 1);
  state_e state, state_nx;
  op_e op_q;
  logic [IW-1:0] idx;
  logic [W-1:0] a_q, b_q, res_q;
  logic phase, t, d0, d1, sel, y, ai, bi, step_done, fin;
  assign ai = a_q[idx];
  assign bi = b_q[idx];
  assign step_done = !two_phase(op_q) || phase;
  assign fin = step_done && idx == LAST;
  // operand routing: phase 0 of two-phase ops produces t, phase 1 consumes it
  always_comb begin
    d0 = 1'b0;
    d1 = ai;
    sel = bi;
    unique case (op_q)
      OP_AND: ;
      OP_OR: begin
        d0 = bi;
        d1 = 1'b1;
        sel = ai;
      end
      OP_XOR: begin
        d0 = phase ? bi : 1'b1;
        d1 = phase ? t : 1'b0;
        sel = phase ? ai : bi;
      end
      OP_NAND: begin
        d0 = phase ? 1'b1 : 1'b0;
        d1 = phase ? 1'b0 : ai;
        sel = phase ? t : bi;
      end
    endcase
  end
  mux u_mux (.d0(d0), .d1(d1), .sel(sel), .y(y));
  always_ff @(posedge clk)
    state <= !rst_n ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (bus.in_valid ? RUN : IDLE)
             : state == RUN  ? (fin ? DONE : RUN)
             : (bus.out_ready ? IDLE : DONE);
  always_comb begin
    bus.in_ready = state == IDLE;
    bus.out_valid = state == DONE;
    bus.out_res = res_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx <= '0;
      phase <= 1'b0;
      t <= 1'b0;
      res_q <= '0;
      a_q <= '0;
      b_q <= '0;
      op_q <= OP_AND;
    end else if (state == IDLE && bus.in_valid) begin
      a_q <= bus.in_a;
      b_q <= bus.in_b;
      op_q <= bus.in_op;
      idx <= '0;
      phase <= 1'b0;
    end else if (state == RUN) begin
      if (!step_done) begin
        t <= y;
        phase <= 1'b1;
      end else begin
        res_q[idx] <= y;
        phase <= 1'b0;
        if (idx != LAST) idx <= idx + 1'b1;
      end
    end
  end
endmodule
